// File: rtl/conv_output_writer.sv
// Output writer: one-pixel holding register between the PE result port and the next layer's FIFO,
// with frame position tracking. Optional build macro OUTPUT_RELU_EN clamps negative lanes at capture.
module conv_output_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_CHANNEL = 16,
  parameter int IN_WIDTH    = 512,
  parameter int IN_HEIGHT   = 256,
  parameter int KERNEL_0    = 4,
  parameter int KERNEL_1    = 4,
  parameter int DILATION_0  = 2,
  parameter int DILATION_1  = 2,
  parameter int PADDING_0   = 2,
  parameter int PADDING_1   = 2,
  parameter int STRIDE_0    = 5,
  parameter int STRIDE_1    = 5,
  parameter int PIXEL_WIDTH = DATA_WIDTH * OUT_CHANNEL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [PIXEL_WIDTH-1:0] i_data,
  output logic                   o_ack,
  output logic                   fifo_wr_en,
  output logic [PIXEL_WIDTH-1:0] fifo_wr_data,
  input  logic                   fifo_almost_full,
  output logic                   o_frame_done,
  output logic                   o_busy
);

  localparam int WINDOW_0   = DILATION_0 * (KERNEL_0 - 1) + 1;
  localparam int WINDOW_1   = DILATION_1 * (KERNEL_1 - 1) + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH  + 2 * PADDING_1 - WINDOW_1) / STRIDE_1 + 1;
  localparam int OUT_HEIGHT = (IN_HEIGHT + 2 * PADDING_0 - WINDOW_0) / STRIDE_0 + 1;
  localparam int COL_W      = $clog2(OUT_WIDTH) + 1;
  localparam int ROW_W      = $clog2(OUT_HEIGHT) + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_HEIGHT - 1);

  // Value stored in the holding register for an incoming PE pixel.
  function automatic logic [PIXEL_WIDTH-1:0] capture_fn(input logic [PIXEL_WIDTH-1:0] pix);
    logic [PIXEL_WIDTH-1:0] res;
    res = pix;
`ifdef OUTPUT_RELU_EN
    for (int i = 0; i < OUT_CHANNEL; i++) begin
      if (pix[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
        res[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end else begin
        res[i*DATA_WIDTH +: DATA_WIDTH] = pix[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`endif
    return res;
  endfunction

  logic                   hold_valid_r;
  logic [PIXEL_WIDTH-1:0] hold_data_r;
  logic [COL_W-1:0]       col_cnt_r;
  logic [ROW_W-1:0]       row_cnt_r;
  logic                   frame_done_r;

  logic drain_s;
  logic accept_s;
  logic col_limit_s;
  logic row_limit_s;

  // Handshake decode: a drain frees the slot, so a new pixel can be taken in the same cycle.
  always_comb begin
    drain_s     = 1'b0;
    accept_s    = 1'b0;
    col_limit_s = 1'b0;
    row_limit_s = 1'b0;
    drain_s     = hold_valid_r & ~fifo_almost_full;
    accept_s    = i_valid & (~hold_valid_r | drain_s);
    col_limit_s = (col_cnt_r == COL_LAST);
    row_limit_s = (row_cnt_r == ROW_LAST);
  end

  assign o_ack        = accept_s;
  assign fifo_wr_en   = drain_s;
  assign fifo_wr_data = hold_data_r;
  assign o_busy       = hold_valid_r;
  assign o_frame_done = frame_done_r;

  // Holding register occupancy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      hold_valid_r <= 1'b1;
    end else if (drain_s) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  // Pixel payload; deliberately unreset since it is qualified by hold_valid_r.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      hold_data_r <= capture_fn(i_data);
    end else begin
      hold_data_r <= hold_data_r;
    end
  end

  // Output raster position and end-of-frame pulse, advanced per pixel written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r    <= {COL_W{1'b0}};
      row_cnt_r    <= {ROW_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= drain_s & col_limit_s & row_limit_s;
      if (drain_s) begin
        if (col_limit_s) begin
          col_cnt_r <= {COL_W{1'b0}};
          if (row_limit_s) begin
            row_cnt_r <= {ROW_W{1'b0}};
          end else begin
            row_cnt_r <= row_cnt_r + ROW_W'(1);
          end
        end else begin
          col_cnt_r <= col_cnt_r + COL_W'(1);
          row_cnt_r <= row_cnt_r;
        end
      end else begin
        col_cnt_r <= col_cnt_r;
        row_cnt_r <= row_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_conv_output_writer.sv
// Self-checking bench for conv_output_writer on a 4x4 output frame (8x8 in, K3 D1 P1 S2).
module tb_conv_output_writer;

  localparam int DW    = 16;
  localparam int OC    = 2;
  localparam int PW    = DW * OC;
  localparam int FRAME = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic [PW-1:0] i_data;
  logic          o_ack;
  logic          fifo_wr_en;
  logic [PW-1:0] fifo_wr_data;
  logic          fifo_almost_full;
  logic          o_frame_done;
  logic          o_busy;

  int total = 0;
  int bad   = 0;

  conv_output_writer #(
    .DATA_WIDTH(DW), .OUT_CHANNEL(OC), .IN_WIDTH(8), .IN_HEIGHT(8),
    .KERNEL_0(3), .KERNEL_1(3), .DILATION_0(1), .DILATION_1(1),
    .PADDING_0(1), .PADDING_1(1), .STRIDE_0(2), .STRIDE_1(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .o_ack(o_ack),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_almost_full(fifo_almost_full),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Reference model: a capacity-one store of pending pixels plus a running write count.
  logic [PW-1:0] mq[$];
  int            writes_m;
  bit            done_m;
  bit            exp_ack, exp_wr, exp_busy, exp_done;
  logic [PW-1:0] exp_data;

  function automatic logic [PW-1:0] relu_m(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    logic signed [DW-1:0] lane;
    r = p;
`ifdef OUTPUT_RELU_EN
    for (int k = 0; k < OC; k++) begin
      lane = p[k*DW +: DW];
      if (lane < 0) r[k*DW +: DW] = '0;
    end
`else
    lane = '0;
`endif
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_pix();
    return PW'($urandom);
  endfunction

  task automatic model_reset();
    mq.delete();
    writes_m = 0;
    done_m   = 1'b0;
  endtask

  task automatic predict();
    exp_busy = (mq.size() != 0);
    exp_wr   = exp_busy && !fifo_almost_full;
    exp_data = exp_busy ? mq[0] : '0;
    exp_ack  = i_valid && (!exp_busy || exp_wr);
    exp_done = done_m;
  endtask

  task automatic commit();
    done_m = 1'b0;
    if (exp_wr) begin
      void'(mq.pop_front());
      writes_m++;
      done_m = (writes_m % FRAME == 0);
    end
    if (exp_ack) mq.push_back(relu_m(i_data));
  endtask

  task automatic drive(input bit v, input logic [PW-1:0] d, input bit af);
    @(posedge clk);
    #1;
    i_valid          = v;
    i_data           = d;
    fifo_almost_full = af;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, rand_pix(), c[0]);
      @(negedge clk);
      total++;
      if ({o_ack, fifo_wr_en, o_frame_done, o_busy} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_outs c=%0d got=%b exp=0000", c, {o_ack, fifo_wr_en, o_frame_done, o_busy});
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [PW-1:0] src[$];
    int dones = 0;
    int w0 = writes_m;
    for (int i = 0; i < FRAME; i++) src.push_back(rand_pix());
    for (int c = 0; c < 22; c++) begin
      drive(src.size() != 0, src.size() != 0 ? src[0] : rand_pix(), 1'b0);
      @(negedge clk);
      predict();
      total++;
      if ({o_ack, fifo_wr_en, o_busy, o_frame_done} !== {exp_ack, exp_wr, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL stream_ctl c=%0d got=%b exp=%b", c,
                 {o_ack, fifo_wr_en, o_busy, o_frame_done}, {exp_ack, exp_wr, exp_busy, exp_done});
      end
      if (exp_wr) begin
        total++;
        if (fifo_wr_data !== exp_data) begin
          bad++;
          $display("FAIL stream_data c=%0d got=%h exp=%h", c, fifo_wr_data, exp_data);
        end
      end
      if (o_frame_done) dones++;
      if (exp_ack) void'(src.pop_front());
      commit();
    end
    total++;
    if (writes_m - w0 != FRAME || dones != 1) begin
      bad++;
      $display("FAIL stream_frame writes=%0d dones=%0d exp 16/1", writes_m - w0, dones);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] a, b;
    a = rand_pix();
    b = rand_pix();
    drive(1'b1, a, 1'b0);
    @(negedge clk);
    predict();
    commit();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, b, 1'b1);
      @(negedge clk);
      predict();
      total++;
      if ({o_ack, fifo_wr_en, o_busy} !== 3'b001 || fifo_wr_data !== relu_m(a)) begin
        bad++;
        $display("FAIL bp_hold c=%0d ack/wr/busy=%b data=%h exp=001/%h", c,
                 {o_ack, fifo_wr_en, o_busy}, fifo_wr_data, relu_m(a));
      end
      commit();
    end
    drive(1'b1, b, 1'b0);
    @(negedge clk);
    predict();
    total++;
    if ({o_ack, fifo_wr_en} !== 2'b11 || fifo_wr_data !== relu_m(a)) begin
      bad++;
      $display("FAIL bp_release ack/wr=%b data=%h exp=11/%h", {o_ack, fifo_wr_en}, fifo_wr_data, relu_m(a));
    end
    commit();
    drive(1'b0, rand_pix(), 1'b0);
    @(negedge clk);
    predict();
    total++;
    if ({o_ack, fifo_wr_en} !== 2'b01 || fifo_wr_data !== relu_m(b)) begin
      bad++;
      $display("FAIL bp_second ack/wr=%b data=%h exp=01/%h", {o_ack, fifo_wr_en}, fifo_wr_data, relu_m(b));
    end
    commit();
  endtask

  task automatic test_relu();
    logic [PW-1:0] pix, want;
    pix = {16'hFFF0, 16'h0007};
`ifdef OUTPUT_RELU_EN
    want = {16'h0000, 16'h0007};
`else
    want = {16'hFFF0, 16'h0007};
`endif
    drive(1'b1, pix, 1'b0);
    @(negedge clk);
    predict();
    commit();
    drive(1'b0, rand_pix(), 1'b0);
    @(negedge clk);
    predict();
    total++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== want) begin
      bad++;
      $display("FAIL relu_lanes wr=%b data=%h exp=1/%h", fifo_wr_en, fifo_wr_data, want);
    end
    commit();
  endtask

  task automatic test_random();
    logic [PW-1:0] src[$];
    for (int i = 0; i < 200; i++) src.push_back(rand_pix());
    for (int c = 0; c < 400; c++) begin
      drive(src.size() != 0 && ($urandom_range(99) < 70),
            src.size() != 0 ? src[0] : rand_pix(), ($urandom_range(99) < 30));
      @(negedge clk);
      predict();
      total++;
      if ({o_ack, fifo_wr_en, o_busy, o_frame_done} !== {exp_ack, exp_wr, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL rand_ctl c=%0d got=%b exp=%b", c,
                 {o_ack, fifo_wr_en, o_busy, o_frame_done}, {exp_ack, exp_wr, exp_busy, exp_done});
      end
      if (exp_wr) begin
        total++;
        if (fifo_wr_data !== exp_data) begin
          bad++;
          $display("FAIL rand_data c=%0d got=%h exp=%h", c, fifo_wr_data, exp_data);
        end
      end
      if (exp_ack) void'(src.pop_front());
      commit();
    end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] src[$];
    int dones = 0;
    int done_at = -1;
    int c = 0;
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, rand_pix(), 1'b0);
    drive(1'b0, rand_pix(), 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) src.push_back(rand_pix());
    while (writes_m < 7 && c < 40) begin
      drive(src.size() != 0, src.size() != 0 ? src[0] : rand_pix(), 1'b0);
      @(negedge clk);
      predict();
      if (exp_ack) void'(src.pop_front());
      commit();
      c++;
    end
    total++;
    if (writes_m != 7) begin
      bad++;
      $display("FAIL midrst_setup writes=%0d exp=7", writes_m);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    total++;
    if ({o_ack, fifo_wr_en, o_frame_done, o_busy} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_outs got=%b exp=0000", {o_ack, fifo_wr_en, o_frame_done, o_busy});
    end
    model_reset();
    drive(1'b0, rand_pix(), 1'b0);
    drive(1'b0, rand_pix(), 1'b0);
    rst_n = 1'b1;
    src.delete();
    for (int i = 0; i < FRAME; i++) src.push_back(rand_pix());
    for (int k = 0; k < 24; k++) begin
      drive(src.size() != 0, src.size() != 0 ? src[0] : rand_pix(), 1'b0);
      @(negedge clk);
      predict();
      total++;
      if ({o_ack, fifo_wr_en, o_busy, o_frame_done} !== {exp_ack, exp_wr, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL midrst_ctl k=%0d got=%b exp=%b", k,
                 {o_ack, fifo_wr_en, o_busy, o_frame_done}, {exp_ack, exp_wr, exp_busy, exp_done});
      end
      if (o_frame_done) begin
        dones++;
        done_at = writes_m;
      end
      if (exp_ack) void'(src.pop_front());
      commit();
    end
    total++;
    if (dones != 1 || done_at != FRAME) begin
      bad++;
      $display("FAIL midrst_frame dones=%0d at_write=%0d exp 1/16", dones, done_at);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    i_valid          = 1'b0;
    i_data           = '0;
    fifo_almost_full = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_relu();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
